// File: rtl/seat_reservation_ctrl.sv
// Multi-seat occupancy controller: owner/state/away-timer per seat, command port with
// ownership checks, and a round-robin scanner that auto-releases seats left AWAY too long.
module seat_reservation_ctrl #(
    parameter int unsigned NUM_SEATS = 32,
    parameter int unsigned ID_W      = 25,
    parameter int unsigned TIME_W    = 11,
    localparam int unsigned SEAT_W   = $clog2(NUM_SEATS),
    localparam int unsigned CNT_W    = $clog2(NUM_SEATS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic [TIME_W-1:0] away_limit,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [SEAT_W-1:0] cmd_seat,
    input  logic [ID_W-1:0]   cmd_id,
    output logic              rsp_valid,
    output logic [2:0]        rsp_code,
    output logic              expire_valid,
    output logic [SEAT_W-1:0] expire_seat,
    output logic [ID_W-1:0]   expire_id,
    input  logic [SEAT_W-1:0] qry_seat,
    output logic [1:0]        qry_state,
    output logic [ID_W-1:0]   qry_id,
    output logic [CNT_W-1:0]  free_count
);

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_OCC  = 2'd1,
        ST_AWAY = 2'd2
    } seat_state_e;

    localparam logic [1:0] OP_CHECK_IN  = 2'd0;
    localparam logic [1:0] OP_AWAY      = 2'd1;
    localparam logic [1:0] OP_RETURN    = 2'd2;

    localparam logic [2:0] RSP_OK        = 3'd0;
    localparam logic [2:0] RSP_BUSY      = 3'd1;
    localparam logic [2:0] RSP_NOT_OWNER = 3'd2;
    localparam logic [2:0] RSP_BAD_STATE = 3'd3;
    localparam logic [2:0] RSP_BAD_SEAT  = 3'd4;
    localparam logic [2:0] RSP_HAS_SEAT  = 3'd5;

    localparam logic [SEAT_W:0]   SEAT_LIMIT = (SEAT_W + 1)'(NUM_SEATS);
    localparam logic [SEAT_W-1:0] SEAT_LAST  = SEAT_W'(NUM_SEATS - 1);

    seat_state_e       state_q [NUM_SEATS];
    seat_state_e       state_d [NUM_SEATS];
    logic [ID_W-1:0]   owner_q [NUM_SEATS];
    logic [ID_W-1:0]   owner_d [NUM_SEATS];
    logic [TIME_W-1:0] timer_q [NUM_SEATS];
    logic [TIME_W-1:0] timer_d [NUM_SEATS];

    logic [SEAT_W-1:0] scan_q, scan_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [2:0]        rsp_code_q, rsp_code_d;
    logic              exp_valid_q, exp_valid_d;
    logic [SEAT_W-1:0] exp_seat_q, exp_seat_d;
    logic [ID_W-1:0]   exp_id_q, exp_id_d;
    logic [CNT_W-1:0]  free_count_q, free_count_d;

    logic        seat_ok_c, qry_ok_c, owner_match_c, collide_c, scan_expirable_c, id_hit_c;
    seat_state_e cur_state_c;
    logic        n_in, n_out, n_rel;

    assign seat_ok_c        = ({1'b0, cmd_seat} < SEAT_LIMIT);
    assign qry_ok_c         = ({1'b0, qry_seat} < SEAT_LIMIT);
    assign cur_state_c      = seat_ok_c ? state_q[cmd_seat] : ST_FREE;
    assign owner_match_c    = seat_ok_c && (owner_q[cmd_seat] == cmd_id);
    assign collide_c        = cmd_valid && (cmd_seat == scan_q);
    assign scan_expirable_c = (state_q[scan_q] == ST_AWAY) && (away_limit != '0)
                              && (timer_q[scan_q] >= away_limit);

    // Parallel ownership compare across all occupied/away seats
    always_comb begin
        id_hit_c = 1'b0;
        for (int i = 0; i < NUM_SEATS; i++) begin
            if ((state_q[i] != ST_FREE) && (owner_q[i] == cmd_id)) begin
                id_hit_c = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        timer_d     = timer_q;
        scan_d      = scan_q;
        rsp_valid_d = cmd_valid;
        rsp_code_d  = rsp_code_q;
        exp_valid_d = 1'b0;
        exp_seat_d  = exp_seat_q;
        exp_id_d    = exp_id_q;
        n_in        = 1'b0;
        n_out       = 1'b0;
        n_rel       = 1'b0;

        for (int i = 0; i < NUM_SEATS; i++) begin
            if (tick && (state_q[i] == ST_AWAY) && (timer_q[i] != '1)) begin
                timer_d[i] = timer_q[i] + TIME_W'(1);
            end
        end

        if (cmd_valid) begin
            if (!seat_ok_c) begin
                rsp_code_d = RSP_BAD_SEAT;
            end else begin
                case (cmd_op)
                    OP_CHECK_IN: begin
                        if (cur_state_c != ST_FREE) begin
                            rsp_code_d = RSP_BUSY;
                        end else if (id_hit_c) begin
                            rsp_code_d = RSP_HAS_SEAT;
                        end else begin
                            rsp_code_d        = RSP_OK;
                            state_d[cmd_seat] = ST_OCC;
                            owner_d[cmd_seat] = cmd_id;
                            n_in              = 1'b1;
                        end
                    end
                    OP_AWAY: begin
                        if (cur_state_c == ST_FREE) begin
                            rsp_code_d = RSP_BAD_STATE;
                        end else if (!owner_match_c) begin
                            rsp_code_d = RSP_NOT_OWNER;
                        end else if (cur_state_c == ST_AWAY) begin
                            rsp_code_d = RSP_BAD_STATE;
                        end else begin
                            rsp_code_d        = RSP_OK;
                            state_d[cmd_seat] = ST_AWAY;
                            timer_d[cmd_seat] = '0;
                        end
                    end
                    OP_RETURN: begin
                        if (cur_state_c == ST_FREE) begin
                            rsp_code_d = RSP_BAD_STATE;
                        end else if (!owner_match_c) begin
                            rsp_code_d = RSP_NOT_OWNER;
                        end else if (cur_state_c != ST_AWAY) begin
                            rsp_code_d = RSP_BAD_STATE;
                        end else begin
                            rsp_code_d        = RSP_OK;
                            state_d[cmd_seat] = ST_OCC;
                        end
                    end
                    default: begin
                        if (cur_state_c == ST_FREE) begin
                            rsp_code_d = RSP_BAD_STATE;
                        end else if (!owner_match_c) begin
                            rsp_code_d = RSP_NOT_OWNER;
                        end else begin
                            rsp_code_d        = RSP_OK;
                            state_d[cmd_seat] = ST_FREE;
                            owner_d[cmd_seat] = '0;
                            n_out             = 1'b1;
                        end
                    end
                endcase
            end
        end

        // Scanner yields to a command on its current seat: no release, no advance
        if (!collide_c) begin
            if (scan_expirable_c) begin
                state_d[scan_q] = ST_FREE;
                owner_d[scan_q] = '0;
                exp_valid_d     = 1'b1;
                exp_seat_d      = scan_q;
                exp_id_d        = owner_q[scan_q];
                n_rel           = 1'b1;
            end
            scan_d = (scan_q == SEAT_LAST) ? '0 : scan_q + SEAT_W'(1);
        end

        for (int i = 0; i < NUM_SEATS; i++) begin
            if (state_d[i] != ST_AWAY) begin
                timer_d[i] = '0;
            end
        end

        free_count_d = free_count_q + CNT_W'(n_out) + CNT_W'(n_rel) - CNT_W'(n_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= '{default: ST_FREE};
            owner_q      <= '{default: '0};
            timer_q      <= '{default: '0};
            scan_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_code_q   <= '0;
            exp_valid_q  <= 1'b0;
            exp_seat_q   <= '0;
            exp_id_q     <= '0;
            free_count_q <= CNT_W'(NUM_SEATS);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            timer_q      <= timer_d;
            scan_q       <= scan_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_code_q   <= rsp_code_d;
            exp_valid_q  <= exp_valid_d;
            exp_seat_q   <= exp_seat_d;
            exp_id_q     <= exp_id_d;
            free_count_q <= free_count_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_code     = rsp_code_q;
    assign expire_valid = exp_valid_q;
    assign expire_seat  = exp_seat_q;
    assign expire_id    = exp_id_q;
    assign free_count   = free_count_q;
    assign qry_state    = qry_ok_c ? state_q[qry_seat] : ST_FREE;
    assign qry_id       = qry_ok_c ? owner_q[qry_seat] : '0;

endmodule

// File: tb/tb_seat_reservation_ctrl.sv
// Bench for seat_reservation_ctrl: directed scenarios plus randomized traffic, all compared
// every cycle against a seat-table reference model.
module tb_seat_reservation_ctrl;
    localparam int NS  = 32;
    localparam int IDW = 25;
    localparam int TW  = 11;
    localparam int SW  = 5;
    localparam int CW  = 6;
    localparam int TMAX = (1 << TW) - 1;
    localparam logic [IDW-1:0] STU = 25'h1ABCDE;

    logic clk, rst_n, tick, cmd_valid;
    logic [TW-1:0] away_limit;
    logic [1:0] cmd_op;
    logic [SW-1:0] cmd_seat, qry_seat, expire_seat;
    logic [IDW-1:0] cmd_id, expire_id, qry_id;
    logic rsp_valid, expire_valid;
    logic [2:0] rsp_code;
    logic [1:0] qry_state;
    logic [CW-1:0] free_count;

    // Six-seat instance: its 3-bit seat index can name seats that do not exist
    logic b_cmd_valid, b_rsp_valid, b_expire_valid;
    logic [1:0] b_cmd_op, b_qry_state;
    logic [2:0] b_cmd_seat, b_qry_seat, b_expire_seat, b_rsp_code, b_free_count;
    logic [IDW-1:0] b_cmd_id, b_expire_id, b_qry_id;

    seat_reservation_ctrl #(.NUM_SEATS(NS), .ID_W(IDW), .TIME_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .away_limit(away_limit),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_seat(cmd_seat), .cmd_id(cmd_id),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code),
        .expire_valid(expire_valid), .expire_seat(expire_seat), .expire_id(expire_id),
        .qry_seat(qry_seat), .qry_state(qry_state), .qry_id(qry_id), .free_count(free_count));

    seat_reservation_ctrl #(.NUM_SEATS(6), .ID_W(IDW), .TIME_W(TW)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(1'b0), .away_limit(11'd0),
        .cmd_valid(b_cmd_valid), .cmd_op(b_cmd_op), .cmd_seat(b_cmd_seat), .cmd_id(b_cmd_id),
        .rsp_valid(b_rsp_valid), .rsp_code(b_rsp_code),
        .expire_valid(b_expire_valid), .expire_seat(b_expire_seat), .expire_id(b_expire_id),
        .qry_seat(b_qry_seat), .qry_state(b_qry_state), .qry_id(b_qry_id),
        .free_count(b_free_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: seat table (0 free, 1 occupied, 2 away), owners, timers, scan position
    int             m_state [NS];
    logic [IDW-1:0] m_owner [NS];
    int             m_timer [NS];
    int             m_ptr;
    bit             e_rsp_valid, e_exp_valid;
    int             e_rsp_code, e_exp_seat;
    logic [IDW-1:0] e_exp_id;

    task automatic m_reset();
        for (int i = 0; i < NS; i++) begin
            m_state[i] = 0; m_owner[i] = '0; m_timer[i] = 0;
        end
        m_ptr = 0; e_rsp_valid = 0; e_exp_valid = 0; e_rsp_code = 0;
        e_exp_seat = 0; e_exp_id = '0;
    endtask

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < NS; i++) if (m_state[i] == 0) n++;
        return n;
    endfunction

    task automatic m_step();
        int os [NS];
        logic [IDW-1:0] oo [NS];
        int ot [NS];
        int s, code;
        bit has;
        os = m_state; oo = m_owner; ot = m_timer;
        e_rsp_valid = cmd_valid;
        e_exp_valid = 0;
        s = int'(cmd_seat);
        if (cmd_valid) begin
            has = 0;
            for (int i = 0; i < NS; i++) if (os[i] != 0 && oo[i] == cmd_id) has = 1;
            if (s >= NS) code = 4;
            else if (int'(cmd_op) == 0) begin
                if (os[s] != 0) code = 1;
                else if (has) code = 5;
                else begin code = 0; m_state[s] = 1; m_owner[s] = cmd_id; end
            end else if (int'(cmd_op) == 1) begin
                if (os[s] == 0) code = 3;
                else if (oo[s] != cmd_id) code = 2;
                else if (os[s] == 2) code = 3;
                else begin code = 0; m_state[s] = 2; end
            end else if (int'(cmd_op) == 2) begin
                if (os[s] == 0) code = 3;
                else if (oo[s] != cmd_id) code = 2;
                else if (os[s] != 2) code = 3;
                else begin code = 0; m_state[s] = 1; end
            end else begin
                if (os[s] == 0) code = 3;
                else if (oo[s] != cmd_id) code = 2;
                else begin code = 0; m_state[s] = 0; m_owner[s] = '0; end
            end
            e_rsp_code = code;
        end
        if (!(cmd_valid && s == m_ptr)) begin
            if (os[m_ptr] == 2 && int'(away_limit) != 0 && ot[m_ptr] >= int'(away_limit)) begin
                m_state[m_ptr] = 0; m_owner[m_ptr] = '0;
                e_exp_valid = 1; e_exp_seat = m_ptr; e_exp_id = oo[m_ptr];
            end
            m_ptr = (m_ptr + 1) % NS;
        end
        for (int i = 0; i < NS; i++) begin
            if (m_state[i] == 2 && os[i] == 2)
                m_timer[i] = (tick && ot[i] < TMAX) ? ot[i] + 1 : ot[i];
            else
                m_timer[i] = 0;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // Cycle-by-cycle comparison against the model
    int n_exp = 0;
    int last_seat = 0;
    logic [IDW-1:0] last_id = '0;
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
            if (e_rsp_valid) chk("rsp_code", 32'(rsp_code), 32'(e_rsp_code));
            chk("expire_valid", 32'(expire_valid), 32'(e_exp_valid));
            if (e_exp_valid) begin
                chk("expire_seat", 32'(expire_seat), 32'(e_exp_seat));
                chk("expire_id", 32'(expire_id), 32'(e_exp_id));
            end
            chk("free_count", 32'(free_count), 32'(m_free()));
            chk("qry_state", 32'(qry_state), 32'(m_state[int'(qry_seat)]));
            chk("qry_id", 32'(qry_id), 32'(m_owner[int'(qry_seat)]));
            if (expire_valid) begin
                n_exp++; last_seat = int'(expire_seat); last_id = expire_id;
            end
        end
    end

    task automatic nxt();
        @(posedge clk); #2;
    endtask

    task automatic do_cmd(input int op, input int seat, input logic [IDW-1:0] id,
                          input int exp, input string name);
        nxt();
        cmd_valid = 1'b1; cmd_op = 2'(op); cmd_seat = SW'(seat); cmd_id = id;
        qry_seat = SW'(seat);
        nxt();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk({name, "_v"}, 32'(rsp_valid), 32'd1);
        chk(name, 32'(rsp_code), 32'(exp));
    endtask

    task automatic b_cmd(input int op, input int seat, input int exp, input string name);
        nxt();
        b_cmd_valid = 1'b1; b_cmd_op = 2'(op); b_cmd_seat = 3'(seat); b_cmd_id = 25'd9;
        nxt();
        b_cmd_valid = 1'b0;
        @(negedge clk);
        chk({name, "_v"}, 32'(b_rsp_valid), 32'd1);
        chk(name, 32'(b_rsp_code), 32'(exp));
    endtask

    initial begin
        int base;
        bit found;
        int lims [5] = '{0, 1, 2, 4, 9};
        rst_n = 1'b0; tick = 1'b0; away_limit = '0; cmd_valid = 1'b0; cmd_op = '0;
        cmd_seat = '0; cmd_id = '0; qry_seat = '0;
        b_cmd_valid = 1'b0; b_cmd_op = '0; b_cmd_seat = '0; b_cmd_id = '0; b_qry_seat = '0;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_code", 32'(rsp_code), 32'd0);
        chk("rst_expire_valid", 32'(expire_valid), 32'd0);
        chk("rst_expire_seat", 32'(expire_seat), 32'd0);
        chk("rst_expire_id", 32'(expire_id), 32'd0);
        chk("rst_free_count", 32'(free_count), 32'd32);
        chk("rst_b_free_count", 32'(b_free_count), 32'd6);
        for (int i = 0; i < NS; i++) begin
            qry_seat = SW'(i); #1;
            chk("rst_qry_state", 32'(qry_state), 32'd0);
            chk("rst_qry_id", 32'(qry_id), 32'd0);
        end
        nxt(); rst_n = 1'b1;

        do_cmd(0, 3, STU, 0, "ci_ok");
        chk("ci_qry_state", 32'(qry_state), 32'd1);
        chk("ci_qry_id", 32'(qry_id), 32'(STU));
        chk("ci_free", 32'(free_count), 32'd31);
        do_cmd(0, 3, 25'h5, 1, "ci_busy");
        do_cmd(0, 4, STU, 5, "ci_has_seat");
        do_cmd(1, 3, 25'h5, 2, "away_not_owner");
        do_cmd(1, 3, STU, 0, "away_ok");
        chk("away_qry_state", 32'(qry_state), 32'd2);
        do_cmd(2, 3, STU, 0, "ret_ok");
        do_cmd(2, 3, STU, 3, "ret_bad_state");
        do_cmd(3, 5, STU, 3, "co_free_bad_state");
        chk("free_after_cmds", 32'(free_count), 32'd31);

        b_cmd(0, 7, 4, "b_bad_seat7");
        b_cmd(3, 6, 4, "b_bad_seat6");
        chk("b_free_bad", 32'(b_free_count), 32'd6);
        b_cmd(0, 5, 0, "b_ci_ok");
        chk("b_free_ok", 32'(b_free_count), 32'd5);
        b_qry_seat = 3'd5; #1;
        chk("b_qry5", 32'(b_qry_state), 32'd1);

        // Expiry after five ticks with limit 5
        nxt(); away_limit = 11'd5;
        do_cmd(1, 3, STU, 0, "away_exp");
        base = n_exp;
        repeat (5) begin nxt(); tick = 1'b1; nxt(); tick = 1'b0; end
        repeat (32) @(negedge clk);
        chk("exp_count", 32'(n_exp - base), 32'd1);
        chk("exp_seat", 32'(last_seat), 32'd3);
        chk("exp_id", 32'(last_id), 32'(STU));
        chk("exp_free", 32'(free_count), 32'd32);
        chk("exp_qry_state", 32'(qry_state), 32'd0);

        // Limit 0 never expires; timer saturates and then meets limit 2047
        nxt(); away_limit = '0;
        do_cmd(0, 3, STU, 0, "ci_sat");
        do_cmd(1, 3, STU, 0, "away_sat");
        base = n_exp;
        nxt(); tick = 1'b1;
        repeat (2100) nxt();
        tick = 1'b0;
        @(negedge clk);
        chk("no_exp_lim0", 32'(n_exp - base), 32'd0);
        chk("lim0_still_away", 32'(qry_state), 32'd2);
        nxt(); away_limit = 11'd2047;
        repeat (33) @(negedge clk);
        chk("sat_exp_count", 32'(n_exp - base), 32'd1);
        chk("sat_exp_seat", 32'(last_seat), 32'd3);

        // RETURN on the scanner's seat while expirable: command wins
        nxt(); away_limit = '0;
        do_cmd(0, 3, STU, 0, "ci_col");
        do_cmd(1, 3, STU, 0, "away_col");
        nxt(); tick = 1'b1; nxt(); tick = 1'b0;
        base = n_exp; found = 0;
        for (int k = 0; k < 70 && !found; k++) begin
            nxt();
            if (m_ptr == 3) found = 1;
        end
        chk("col_ptr_found", 32'(found), 32'd1);
        away_limit = 11'd1;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_seat = 5'd3; cmd_id = STU; qry_seat = 5'd3;
        nxt(); cmd_valid = 1'b0;
        @(negedge clk);
        chk("col_rsp", 32'(rsp_code), 32'd0);
        chk("col_state", 32'(qry_state), 32'd1);
        repeat (40) @(negedge clk);
        chk("col_no_exp", 32'(n_exp - base), 32'd0);
        chk("col_still_occ", 32'(qry_state), 32'd1);

        // Reset mid-sweep with an away seat and a command in flight
        nxt(); away_limit = '0;
        do_cmd(0, 10, 25'd77, 0, "ci_rst");
        do_cmd(1, 10, 25'd77, 0, "away_rst");
        nxt(); tick = 1'b1; away_limit = 11'd1;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_seat = 5'd11; cmd_id = 25'd78;
        @(posedge clk); #1;
        rst_n = 1'b0; cmd_valid = 1'b0; tick = 1'b0; away_limit = '0;
        #1;
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_code", 32'(rsp_code), 32'd0);
        chk("mid_rst_expire_valid", 32'(expire_valid), 32'd0);
        chk("mid_rst_free", 32'(free_count), 32'd32);
        nxt(); nxt(); rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("post_rst_expire_valid", 32'(expire_valid), 32'd0);
        end

        // Randomized traffic concentrated on a few seats and IDs
        for (int c = 0; c < 3000; c++) begin
            nxt();
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = 2'($urandom_range(0, 3));
            cmd_seat = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, NS - 1))
                                                  : SW'($urandom_range(0, 5));
            cmd_id = IDW'($urandom_range(1, 5));
            tick = ($urandom_range(0, 2) == 0);
            qry_seat = SW'($urandom_range(0, 7));
            if (c % 250 == 0) away_limit = TW'(lims[$urandom_range(0, 4)]);
        end
        nxt(); cmd_valid = 1'b0; tick = 1'b0;
        repeat (3) nxt();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
